reg_file: RTL
=============

Name: reg_file

Overview:
- RV32I integer register file: 32 x XLEN storage, one synchronous write port, two combinational read ports.
- Read side of the datapath's register storage. The decode stage reads rs1/rs2 through it; the writeback stage writes rd.
- x0 is hardwired to zero.
- Same-cycle write-to-read bypass, so a value written by writeback is visible to decode in the same cycle.

Parameters:
- XLEN, 32, width of each register and of all data ports.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- AW, 5, address width; must equal log2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rs1_addr  input  AW  read port 1 register index.
- rs2_addr  input  AW  read port 2 register index.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- we  input  1  write enable from writeback.
- rd_addr  input  AW  write register index.
- rd_data  input  XLEN  write data.
- wr_count  output  16  saturating count of committed writes, for debug and verification.

Behaviour:
- Reset:
  - Reset is synchronous and active-high: on a rising clk edge with rst=1, all NREGS registers clear to 0 and wr_count clears to 0.
  - While rst=1, read outputs reflect the cleared contents from the cycle after the reset edge.
  - rst has priority over we on the same edge; that write is discarded.
- Write:
  - On a rising edge with rst=0, we=1 and rd_addr!=0, register[rd_addr] <= rd_data and wr_count increments.
  - we=1 with rd_addr=0: no state change and no count increment.
  - we=0: all registers hold.
- Storage element: each register is an XLEN-bit load-enabled register. Its load is (we & rd_addr==i & i!=0 & !rst), or the reset path for rst.
- Read:
  - rsN_data is purely combinational from rsN_addr and current state. No read latency, no clock involvement.
  - rsN_addr=0 always yields 0, regardless of we/rd_addr/rd_data.
- Bypass:
  - If we=1, rd_addr!=0, rst=0 and rsN_addr==rd_addr, then rsN_data=rd_data in that same cycle (write-first).
  - Otherwise rsN_data=register[rsN_addr].
- Both ports are independent:
  - rs1_addr==rs2_addr returns identical data on both.
  - Both may bypass simultaneously.
- wr_count saturates at 16'hFFFF and holds there; it does not wrap.
- Out-of-range addresses are impossible by construction, since AW=log2(NREGS).
- No X propagation after the first reset: every register has a defined value.
- Before the first reset, contents are unspecified; the bench must apply reset first.

Test Plan:
- Reset clear: write x5=32'hDEADBEEF, then assert rst for 1 cycle -> rs1_addr=5 reads 0 and wr_count=0 on the cycle after the reset edge.
- Basic write/read: we=1, rd_addr=10, rd_data=32'h1234_5678, one edge, we=0; rs1_addr=10, rs2_addr=10 -> both ports read 32'h1234_5678, wr_count=1.
- x0 immunity: we=1, rd_addr=0, rd_data=32'hFFFF_FFFF, one edge; rs1_addr=0 -> rs1_data=0 both during and after the edge, wr_count unchanged.
- Bypass: x7 holds 32'h0000_0011; in one cycle set we=1, rd_addr=7, rd_data=32'h0000_0022, rs1_addr=7, rs2_addr=8 -> rs1_data=32'h22 before the edge, rs2_data=old x8. After the edge with we=0, rs1_data still reads 32'h22.
- Reset vs write collision: rst=1 and we=1, rd_addr=3, rd_data=32'hA5A5_A5A5 on the same edge -> x3 reads 0 afterwards, wr_count=0. During rst=1, rs1_addr=3 must not bypass A5A5_A5A5.
- Sweep and count: write xi = i*32'h0101_0101 for i=1..31, then read all pairs (rs1=i, rs2=31-i) -> each matches its written value, x0 reads 0, wr_count=31. Force 65540 writes -> wr_count=16'hFFFF.

Source files
------------

// File: rtl/reg_file_if.sv
// Register-file access bus: decode-side read ports, writeback-side write port
// and the debug write counter.
interface reg_file_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [15:0]     wr_count;

  // Pipeline side: issues read indices and writeback, observes read data.
  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, rd_data,
    input  rs1_data, rs2_data, wr_count
  );

  // Register file side.
  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, rd_data,
    output rs1_data, rs2_data, wr_count
  );
endinterface

// File: rtl/reg_file.sv
// RV32I integer register file: NREGS x XLEN storage, one synchronous write
// port, two combinational read ports with write-first bypass, x0 reads zero.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input logic         clk,
  input logic         rst,
  reg_file_if.slave   bus
);

  logic [XLEN-1:0] regs [NREGS];
  logic [15:0]     wr_count_q;
  logic            wr_hit;

  // Saturating increment for the debug write counter; holds at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // Read mux: x0 is zero, a live write to the same index wins over storage.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   a,
    input logic            hit,
    input logic [AW-1:0]   wa,
    input logic [XLEN-1:0] wd,
    input logic [XLEN-1:0] stored
  );
    if (a == '0)            return '0;
    if (hit && (a == wa))   return wd;
    return stored;
  endfunction

  // A write commits only with rst low and a non-zero destination.
  always_comb begin
    wr_hit = bus.we && (bus.rd_addr != '0) && !rst;
  end

  // Storage update: reset clears everything, otherwise load the addressed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[bus.rd_addr] <= bus.rd_data;
    end
  end

  // Committed-write counter, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)         wr_count_q <= '0;
    else if (wr_hit) wr_count_q <= sat_inc(wr_count_q);
  end

  // Combinational read ports.
  always_comb begin
    bus.rs1_data = read_port(bus.rs1_addr, wr_hit, bus.rd_addr, bus.rd_data,
                             regs[bus.rs1_addr]);
    bus.rs2_data = read_port(bus.rs2_addr, wr_hit, bus.rd_addr, bus.rd_data,
                             regs[bus.rs2_addr]);
  end

  assign bus.wr_count = wr_count_q;

endmodule
